// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with a 2-entry skid buffer, valid/ready handshake and flush-to-bubble.
// Optional perf counters (stall_cnt, bubble_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(32'h0000_0013),
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] main_addr_q, main_addr_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire, out_fire;

    // in_ready comes straight from state; rst is the only combinational term.
    assign in_ready  = !rst && (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign out_addr  = main_addr_q;
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_addr_d = main_addr_q;
        main_data_d = main_data_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Anything accepted this cycle is dropped; out_addr keeps its last value.
            state_d     = S_EMPTY;
            main_data_d = NOP_INSTR;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d     = S_ONE;
                        main_addr_d = in_addr;
                        main_data_d = in_data;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_addr_d = in_addr;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        state_d     = S_FULL;
                        skid_addr_d = in_addr;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        state_d     = S_EMPTY;
                        main_data_d = NOP_INSTR;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        state_d     = S_ONE;
                        main_addr_d = skid_addr_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d     = S_EMPTY;
                    main_data_d = NOP_INSTR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            main_addr_q <= '0;
            main_data_q <= NOP_INSTR;
            skid_addr_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_addr_q <= main_addr_d;
            main_data_q <= main_data_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

    // Saturating counters; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (!out_valid && (bubble_cnt_q != '1))
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
